blocked_systolic_mac: RTL and testbench
=======================================

Name: blocked_systolic_mac

Overview:
- Fixed-point block matrix-multiply core built around a BLOCK_SIZE x BLOCK_SIZE output-stationary systolic array.
- One "run" multiplies one A block (west input) by one B block (north input); a block accumulator sums K = INNER_DIMENSION/BLOCK_SIZE runs into one C block.
- Sits between the A/B block RAMs (driven by an external address sequencer) and the result sink.

Parameters:
- WIDTH, 16, bits per element; signed two's complement.
- FRAC_WIDTH, 8, fractional bits (Q8.8 by default).
- BLOCK_SIZE, 2, systolic array dimension N.
- INNER_DIMENSION, 8, shared dimension of A and B; must be a multiple of BLOCK_SIZE.
- CHUNK_SIZE, 4, elements per bus; must equal BLOCK_SIZE*BLOCK_SIZE.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset of the systolic array and run sequencer; it also restarts a run.
- reset_acc, input, 1, active-low synchronous clear of the accumulator bank.
- en, input, 1, run enable; when low, all run state holds.
- input_w, input, WIDTH*CHUNK_SIZE, A block, row-major. Element i=r*N+k occupies bits [(CHUNK_SIZE-i)*WIDTH-1 -: WIDTH], so element 0 is at the MSBs.
- input_n, input, WIDTH*CHUNK_SIZE, B block, column-major. Element i=c*N+k = B[k][c], same bit placement as input_w.
- accumulator_done, output, 1, high when `out` holds a complete K-run sum.
- systolic_finish, output, 1, high when the current run's block product is complete.
- out, output, WIDTH*CHUNK_SIZE, accumulated C block, row-major, same bit placement.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Clears every PE, all skew registers, the cycle counter, and systolic_finish.
  - Does not touch the accumulator bank, out, or accumulator_done.
- Run sequencing:
  - The cycle counter increments on each clk with rst_n=1 and en=1.
  - Internal skew registers feed row r of A delayed by r cycles and column c of B delayed by c cycles.
  - input_w and input_n must be held stable for the whole run.
- Processing elements:
  - Each PE(r,c) computes acc += (a*b) >>> FRAC_WIDTH each valid cycle.
  - The product is full 2*WIDTH signed, arithmetically shifted, then truncated to WIDTH.
  - The PE sum wraps modulo 2^WIDTH.
- Run completion:
  - systolic_finish registers high on the edge where the counter reaches 3N-2 (cycle 4 for N=2).
  - It stays high, with the counter frozen, until rst_n is asserted.
  - The upstream controller pulses rst_n low for at least one cycle to start the next run.
- Accumulate event:
  - Occurs in the single cycle where systolic_finish rises, detected internally against its registered previous value.
  - Every accumulator element adds the matching PE value with WIDTH-bit wrap.
  - The run count increments.
- Block completion:
  - When the run count reaches K, the same edge sets accumulator_done=1 and out reflects the final sum.
  - accumulator_done holds until cleared.
- Start of a new sum:
  - An accumulate event while accumulator_done=1 loads the PE values instead of adding them.
  - It sets the count to 1 and clears accumulator_done.
- reset_acc=0 (synchronous):
  - Clears accumulators, count, out, and accumulator_done.
  - Has priority over a simultaneous accumulate event.
- Power-up: the integrator holds reset_acc=0 for at least one clk so that out=0 and accumulator_done=0.
- Output register: out is the accumulator register itself (zero extra latency).
- en=0: freezes the counter and PEs. A pending accumulate event still fires because it depends only on the systolic_finish edge.
- Mid-run rst_n: aborts the run; the partial result is never accumulated and the run count is unchanged.

Optional Feature:
- SYSTOLIC_SATURATE_EN defined:
  - PE truncation and accumulator addition saturate to the signed limits 0x7FFF and 0x8000 (for WIDTH=16).
- SYSTOLIC_SATURATE_EN undefined: wrap-around arithmetic as specified above.

Decomposition:
- Shared package systolic_pkg holds:
  - Element slice helper functions (index to bit offset).
  - A localparam function computing K.
  - A localparam function computing the finish cycle 3N-2.
  - The fixed-point multiply-shift-truncate/saturate function.
- One natural sub-module, systolic_pe:
  - Contains the MAC, the east pass register, and the south pass register.
  - Instantiated N*N times via generate.

Test Plan:
- Single run, Q8.8: A=I (0x0100 0 0 0x0100), B=[[1,2],[3,4]] → systolic_finish high 4 cycles after release with en=1; PE values 0x0100, 0x0200, 0x0300, 0x0400.
- Full block, K=4: four identical runs as above with an rst_n pulse between runs → accumulator_done=1 after run 4; out=0x0400,0x0800,0x0C00,0x1000.
- New sum: a fifth run with A=I, B=all 0x0100 → out=0x0100 x4; accumulator_done=0; count=1.
- Negative/fraction: A=[[0xFF80(-0.5),0],[0,0x0080]], B=I → PE values 0xFF80, 0, 0, 0x0080.
- Overflow: A and B elements 0x7F00 → wrapped result without SYSTOLIC_SATURATE_EN; 0x7FFF with it.
- Controls:
  - rst_n low at cycle 2 of a run → no accumulate event; count unchanged.
  - reset_acc=0 coinciding with a systolic_finish rise → out=0, accumulator_done=0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared helpers for the blocked systolic MAC: element slicing, run geometry, fixed-point math.
// Define SYSTOLIC_SATURATE_EN to make PE and accumulator arithmetic saturate instead of wrap.
package systolic_pkg;

`ifdef SYSTOLIC_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  // Element 0 sits at the MSBs of a bus.
  function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned width,
                                           input int unsigned chunk);
    return (chunk - 1 - idx) * width;
  endfunction

  function automatic int unsigned calc_k(input int unsigned inner, input int unsigned n);
    return inner / n;
  endfunction

  function automatic int unsigned calc_finish(input int unsigned n);
    return 3 * n - 2;
  endfunction

  // Fit a wide signed value into width bits, sign-extended back to 64.
  function automatic logic signed [63:0] fx_fit(input logic signed [63:0] v,
                                                input int unsigned width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (SatEn) begin
      if (v > max_v) return max_v;
      if (v < min_v) return min_v;
    end
    return (v <<< (64 - width)) >>> (64 - width);
  endfunction

  function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                input logic signed [63:0] b,
                                                input int unsigned frac,
                                                input int unsigned width);
    return fx_fit((a * b) >>> frac, width);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: fixed-point MAC plus east/south pass registers.
// Arithmetic follows systolic_pkg (wrap, or saturate under SYSTOLIC_SATURATE_EN).
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FRAC_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_a,
  output logic signed [WIDTH-1:0] o_b,
  output logic signed [WIDTH-1:0] o_acc
);

  logic signed [WIDTH-1:0] r_a, r_b, r_acc;
  logic signed [63:0]      w_term;
  logic signed [WIDTH-1:0] w_sum;

  assign w_term = fx_mul(64'(i_a), 64'(i_b), FRAC_WIDTH, WIDTH);
  assign w_sum  = WIDTH'(fx_fit(64'(r_acc) + w_term, WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_valid) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= w_sum;
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/blocked_systolic_mac.sv
// Block matrix-multiply core: NxN systolic array plus a K-run block accumulator.
// Define SYSTOLIC_SATURATE_EN for saturating arithmetic (default build wraps).
module blocked_systolic_mac
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned FRAC_WIDTH      = 8,
  parameter int unsigned BLOCK_SIZE      = 2,
  parameter int unsigned INNER_DIMENSION = 8,
  parameter int unsigned CHUNK_SIZE      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        reset_acc,
  input  logic                        en,
  input  logic [WIDTH*CHUNK_SIZE-1:0] input_w,
  input  logic [WIDTH*CHUNK_SIZE-1:0] input_n,
  output logic                        accumulator_done,
  output logic                        systolic_finish,
  output logic [WIDTH*CHUNK_SIZE-1:0] out
);

  localparam int unsigned N        = BLOCK_SIZE;
  localparam int unsigned K        = calc_k(INNER_DIMENSION, N);
  localparam int unsigned FinCycle = calc_finish(N);
  localparam int unsigned CntW     = $clog2(FinCycle + 1);
  localparam int unsigned RunW     = $clog2(K + 1);

  logic [CntW-1:0]         r_cnt;
  logic                    r_finish, r_finish_q;
  logic                    w_valid, w_acc_event;
  logic signed [WIDTH-1:0] w_feed_w [N];
  logic signed [WIDTH-1:0] w_feed_n [N];
  logic signed [WIDTH-1:0] w_pe_a   [N][N];
  logic signed [WIDTH-1:0] w_pe_b   [N][N];
  logic signed [WIDTH-1:0] w_pe_acc [N][N];
  logic signed [WIDTH-1:0] r_acc    [CHUNK_SIZE];
  logic [RunW-1:0]         r_runs;
  logic                    r_done;

  assign w_valid     = en & ~r_finish;
  assign w_acc_event = r_finish & ~r_finish_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_finish   <= 1'b0;
      r_finish_q <= 1'b0;
    end else begin
      r_finish_q <= r_finish;
      if (w_valid) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CntW'(FinCycle - 1)) r_finish <= 1'b1;
      end
    end
  end

  // Skew is derived from the run counter: row/column j sees element k at cycle j+k.
  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      w_feed_w[j] = '0;
      w_feed_n[j] = '0;
      for (int unsigned k = 0; k < N; k++) begin
        if (r_cnt == CntW'(j + k)) begin
          w_feed_w[j] = input_w[elem_lsb(j * N + k, WIDTH, CHUNK_SIZE) +: WIDTH];
          w_feed_n[j] = input_n[elem_lsb(j * N + k, WIDTH, CHUNK_SIZE) +: WIDTH];
        end
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic signed [WIDTH-1:0] w_a_in, w_b_in;
      if (c == 0) begin : g_w_edge
        assign w_a_in = w_feed_w[r];
      end else begin : g_w_chain
        assign w_a_in = w_pe_a[r][c-1];
      end
      if (r == 0) begin : g_n_edge
        assign w_b_in = w_feed_n[c];
      end else begin : g_n_chain
        assign w_b_in = w_pe_b[r-1][c];
      end
      systolic_pe #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
      ) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_valid),
        .i_a     (w_a_in),
        .i_b     (w_b_in),
        .o_a     (w_pe_a[r][c]),
        .o_b     (w_pe_b[r][c]),
        .o_acc   (w_pe_acc[r][c])
      );
    end
  end

  // Accumulator bank lives outside the rst_n domain so aborted runs never disturb it.
  always_ff @(posedge clk) begin
    if (!reset_acc) begin
      for (int unsigned i = 0; i < CHUNK_SIZE; i++) r_acc[i] <= '0;
      r_runs <= '0;
      r_done <= 1'b0;
    end else if (w_acc_event) begin
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          r_acc[r*N+c] <= r_done ? w_pe_acc[r][c] :
              WIDTH'(fx_fit(64'(r_acc[r*N+c]) + 64'(w_pe_acc[r][c]), WIDTH));
        end
      end
      if (r_done) begin
        r_runs <= RunW'(1);
        r_done <= 1'b0;
      end else begin
        r_runs <= r_runs + 1'b1;
        if (r_runs == RunW'(K - 1)) r_done <= 1'b1;
      end
    end
  end

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < CHUNK_SIZE; i++) begin
      out[elem_lsb(i, WIDTH, CHUNK_SIZE) +: WIDTH] = r_acc[i];
    end
  end

  assign accumulator_done = r_done;
  assign systolic_finish  = r_finish;

endmodule

// File: tb/tb_blocked_systolic_mac.sv
// Self-checking bench for blocked_systolic_mac (N=2, K=4, Q8.8) with a scoreboard model.
module tb_blocked_systolic_mac;

  logic        clk = 1'b0;
  logic        rst_n, reset_acc, en;
  logic [63:0] input_w, input_n, out;
  logic        accumulator_done, systolic_finish;

  always #5 clk = ~clk;

  blocked_systolic_mac #(
    .WIDTH           (16),
    .FRAC_WIDTH      (8),
    .BLOCK_SIZE      (2),
    .INNER_DIMENSION (8),
    .CHUNK_SIZE      (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .reset_acc        (reset_acc),
    .en               (en),
    .input_w          (input_w),
    .input_n          (input_n),
    .accumulator_done (accumulator_done),
    .systolic_finish  (systolic_finish),
    .out              (out)
  );

  typedef struct {
    logic [63:0] out;
    logic        done;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic signed [15:0] m_acc[4];
  int                 m_runs;
  logic               m_done;

  localparam logic [63:0] AI    = 64'h0100_0000_0000_0100;
  localparam logic [63:0] B1234 = 64'h0100_0300_0200_0400;
  localparam logic [63:0] C1234 = 64'h0100_0200_0300_0400;
  localparam logic [63:0] BONES = 64'h0100_0100_0100_0100;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic signed [15:0] fit16(input logic signed [31:0] v);
`ifdef SYSTOLIC_SATURATE_EN
    if (v > 32'sd32767) return 16'sh7fff;
    if (v < -32'sd32768) return 16'sh8000;
`endif
    return v[15:0];
  endfunction

  function automatic logic [63:0] model_block(input logic [63:0] a, input logic [63:0] b);
    logic [63:0]        res;
    logic signed [15:0] ae, be, s;
    logic signed [31:0] p;
    res = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        s = '0;
        for (int k = 0; k < 2; k++) begin
          ae = a[(3 - (r * 2 + k)) * 16 +: 16];
          be = b[(3 - (c * 2 + k)) * 16 +: 16];
          p  = ae * be;
          s  = fit16(32'(s) + 32'(fit16(p >>> 8)));
        end
        res[(3 - (r * 2 + c)) * 16 +: 16] = s;
      end
    end
    return res;
  endfunction

  function automatic logic [63:0] model_pack();
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[(3 - i) * 16 +: 16] = m_acc[i];
    return v;
  endfunction

  task automatic model_event(input logic [63:0] pe, input bit clr);
    exp_t               e;
    logic signed [15:0] t;
    if (clr) begin
      for (int i = 0; i < 4; i++) m_acc[i] = '0;
      m_runs = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      for (int i = 0; i < 4; i++) m_acc[i] = pe[(3 - i) * 16 +: 16];
      m_runs = 1;
      m_done = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        t        = pe[(3 - i) * 16 +: 16];
        m_acc[i] = fit16(32'(m_acc[i]) + 32'(t));
      end
      m_runs++;
      if (m_runs == 4) m_done = 1'b1;
    end
    e.out  = model_pack();
    e.done = m_done;
    sb.push_back(e);
  endtask

  task automatic clear_acc();
    @(negedge clk);
    reset_acc = 1'b0;
    @(negedge clk);
    reset_acc = 1'b1;
    for (int i = 0; i < 4; i++) m_acc[i] = '0;
    m_runs = 0;
    m_done = 1'b0;
    check("clear_out", out, 64'h0);
    check("clear_done", {63'h0, accumulator_done}, 64'h0);
  endtask

  // One run: rst_n pulse, optional en gap, then the accumulate event after finish rises.
  task automatic do_run(input logic [63:0] a, input logic [63:0] b, input int gap,
                        input bit clr_at_event, input bit drop_en);
    exp_t        e;
    logic [63:0] prev;
    int          lat;
    @(negedge clk);
    input_w = a;
    input_n = b;
    rst_n   = 1'b0;
    en      = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    prev  = model_pack();
    model_event(model_block(a, b), clr_at_event);
    @(negedge clk);
    lat = 1;
    if (gap > 0) begin
      en = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        lat++;
      end
      en = 1'b1;
    end
    while (!systolic_finish && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("finish_latency", 64'(lat), 64'(4 + gap));
    check("pre_event_out", out, prev);
    if (clr_at_event) reset_acc = 1'b0;
    if (drop_en) en = 1'b0;
    @(negedge clk);
    reset_acc = 1'b1;
    en        = 1'b1;
    e = sb.pop_front();
    check("sb_out", out, e.out);
    check("sb_done", {63'h0, accumulator_done}, {63'h0, e.done});
    check("finish_hold", {63'h0, systolic_finish}, 64'h1);
  endtask

  initial begin
    rst_n     = 1'b0;
    reset_acc = 1'b0;
    en        = 1'b0;
    input_w   = '0;
    input_n   = '0;
    for (int i = 0; i < 4; i++) m_acc[i] = '0;
    m_runs = 0;
    m_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", out, 64'h0);
    check("reset_done", {63'h0, accumulator_done}, 64'h0);
    check("reset_finish", {63'h0, systolic_finish}, 64'h0);
    reset_acc = 1'b1;

    tbl[0] = '{"identity", AI, B1234, C1234};
    tbl[1] = '{"neg_half", 64'hFF80_0000_0000_0080, AI, 64'hFF80_0000_0000_0080};
`ifdef SYSTOLIC_SATURATE_EN
    tbl[2] = '{"overflow", 64'h7F00_7F00_7F00_7F00, 64'h7F00_7F00_7F00_7F00,
               64'h7FFF_7FFF_7FFF_7FFF};
`else
    tbl[2] = '{"overflow", 64'h7F00_7F00_7F00_7F00, 64'h7F00_7F00_7F00_7F00,
               64'h0200_0200_0200_0200};
`endif
    tbl[3] = '{"ints", C1234, 64'h0500_0700_0600_0800, 64'h1300_1600_2B00_3200};
    tbl[4] = '{"mixed_frac", 64'h0180_FF00_0040_0200, 64'h0200_0100_FF80_0100,
               64'h0200_FE40_0280_01E0};
    tbl[5] = '{"floor_shift", 64'h0001_0000_0000_FFFF, 64'h0080_0000_0000_0080,
               64'h0000_0000_0000_FFFF};

    for (int i = 0; i < 6; i++) begin
      clear_acc();
      do_run(tbl[i].a, tbl[i].b, 0, 1'b0, 1'b0);
      check(tbl[i].name, out, tbl[i].c);
    end

    // Full K=4 block, with an en gap on run 2 and en dropped at the event on run 3.
    clear_acc();
    for (int j = 0; j < 4; j++) do_run(AI, B1234, (j == 1) ? 3 : 0, 1'b0, j == 2);
    check("block_out", out, 64'h0400_0800_0C00_1000);
    check("block_done", {63'h0, accumulator_done}, 64'h1);
    repeat (3) @(negedge clk);
    check("block_hold", out, 64'h0400_0800_0C00_1000);

    // New sum loads; three more runs close the block again.
    do_run(AI, BONES, 0, 1'b0, 1'b0);
    check("newsum_out", out, BONES);
    check("newsum_done", {63'h0, accumulator_done}, 64'h0);
    for (int j = 0; j < 3; j++) do_run(AI, BONES, 0, 1'b0, 1'b0);
    check("newsum_block", out, 64'h0400_0400_0400_0400);

    // reset_acc low on the accumulate edge wins.
    do_run(AI, B1234, 0, 1'b1, 1'b0);
    check("clr_evt_out", out, 64'h0);
    check("clr_evt_done", {63'h0, accumulator_done}, 64'h0);
    do_run(AI, B1234, 0, 1'b0, 1'b0);
    check("after_clr_out", out, C1234);

    // Mid-run abort must not accumulate or bump the run count.
    @(negedge clk);
    input_w = C1234;
    input_n = 64'h0500_0700_0600_0800;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_finish", {63'h0, systolic_finish}, 64'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out", out, C1234);
    for (int j = 0; j < 3; j++) do_run(AI, B1234, 0, 1'b0, 1'b0);
    check("abort_block", out, 64'h0400_0800_0C00_1000);
    check("abort_done", {63'h0, accumulator_done}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
